rggen_bus_responder_ram: RTL
============================

# rggen_bus_responder_ram

Responder end of the rggen bus protocol: accepts requests on an `rggen_bus_if.slave` port, services them against an internal word array with byte strobes, and returns status and read data after a configurable number of wait states. It sits behind an external-register initiator, standing in for the external register block. It is used as a synthesizable scratch register file and as the standard target model in external-register testbenches.

## Interface
- `ADDRESS_WIDTH`, default 8: width of `bus_if.address`.
- `BUS_WIDTH`, default 32: data width; must be a power of two, at least 8.
- `WORDS`, default 4: number of storage words; must be at least 1.
- `BASE_ADDRESS`, default `'0`: byte address of word 0; must be aligned to `BUS_WIDTH/8`.
- `WAIT_CYCLES`, default 0: wait states inserted before `ready`; honoured only with `RGGEN_BUS_RESPONDER_WAIT_EN`.
- `i_clk`, input, 1 bit: clock.
- `i_rst_n`, input, 1 bit: asynchronous, active-low reset.
- `bus_if`, interface, `rggen_bus_if.slave`:
  - inputs: `valid`, `address`, `write`, `write_data`, `strobe` (`BUS_WIDTH/8` byte enables);
  - outputs: `ready`, `status`, `read_data`.
- `o_value`, output, `WORDS*BUS_WIDTH` bits: storage contents; word i is at bits `[i*BUS_WIDTH +: BUS_WIDTH]`.

## Operation
- State machine: IDLE, WAIT, RESPOND.
- IDLE:
  - `valid=1` means the request is accepted at this edge and executes immediately from the bus inputs.
  - Go to RESPOND if the effective wait is 0; otherwise load the counter with wait−1 and go to WAIT.
- WAIT: the counter decrements each cycle. Go to RESPOND when the counter is 0. `valid` is ignored.
- RESPOND: `ready=1` for exactly one cycle, then always return to IDLE.
  - The initiator clears `valid` on the same edge, so IDLE never re-accepts the same request.
- Address decode:
  - in range when `BASE_ADDRESS <= address <= BASE_ADDRESS + (WORDS-1)*BUS_WIDTH/8`;
  - word index = (address − BASE_ADDRESS) >> log2(BUS_WIDTH/8); low address bits are ignored.
- In-range write:
  - each byte with a set `strobe` bit is updated;
  - `strobe` all zero leaves storage unchanged and returns status OKAY;
  - `read_data` is 0.
- In-range read: `read_data` = the addressed word; `strobe` is ignored; status OKAY.
- Out-of-range access: status SLAVE_ERROR, `read_data` = 0, storage unchanged.
- `status` and `read_data` are registered at the accept edge. They hold until the next accept and are valid whenever `ready=1`.

## Timing
- Reset values: state IDLE, `ready=0`, `status=OKAY`, `read_data=0`, all storage 0 (so `o_value=0`), counter 0.
- Latency: with `valid` first high in IDLE cycle C, `ready` is high only in cycle C+1+N (N = effective wait).
- A write is visible on `o_value` from cycle C+1, before `ready`.
- Back-to-back: a new `valid` in the cycle after RESPOND is accepted in that cycle. Maximum throughput is one access per N+2 cycles.
- Reset asserted mid-transaction (WAIT or RESPOND): immediate return to IDLE and `ready=0`. The pending response is dropped and storage is cleared.
- `ready` is registered and never depends combinationally on `valid`.

## Configuration
- `RGGEN_BUS_RESPONDER_WAIT_EN` defined: effective wait N = `WAIT_CYCLES`; the WAIT state and counter (width `$clog2(WAIT_CYCLES+1)`, minimum 1) are built.
- Not defined: N = 0 regardless of `WAIT_CYCLES`; there is no WAIT state and no counter; `ready` is always at C+1.

## Structure
- `rggen_rtl_pkg` holds the shared `rggen_status` encoding (OKAY, EXOKAY, SLAVE_ERROR, DECODE_ERROR).
- The state enum and ADDRESS_LSB/index-width localparams stay local to the module.
- Range checking reuses `rggen_address_decoder`:
  - START/END set as above, READABLE and WRITABLE set to 1, LSB = ADDRESS_LSB, `i_additional_match` tied to 1.
- No new sub-module.

## Test plan
Bench configuration: `BUS_WIDTH=32`, `WORDS=4`, `BASE_ADDRESS=8'h10`, `WAIT_CYCLES=2`, macro defined unless noted.
- Full write: write 0x10 with 0xDEADBEEF, strobe 4'hF, valid at cycle C.
  - Required: word0 = 0xDEADBEEF at C+1; `ready` only at C+3; status OKAY.
- Partial write: word1 = 0x11223344; write 0x14 with 0x0000AB00, strobe 4'b0010.
  - Required: word1 = 0x1122AB44.
- Read and decode errors:
  - read 0x1C → `read_data` = word3, OKAY;
  - read 0x20 → SLAVE_ERROR, `read_data` 0;
  - write 0x08 → SLAVE_ERROR, `o_value` unchanged.
- Back-to-back: second request raises `valid` the cycle after `ready`.
  - Required: accepted; exactly one `ready` per request; 4 cycles apart.
- Reset during WAIT (`i_rst_n` low at C+2).
  - Required: `ready` stays 0, `o_value=0`, state IDLE; the next request completes normally.
- Macro undefined, same stimulus as the full write.
  - Required: `ready` at C+1 with `WAIT_CYCLES=2`.

Source files
------------

// File: rtl/rggen_rtl_pkg.sv
// Shared definitions for the rggen bus: the response status encoding used by
// initiators and responders alike.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

endpackage

// File: rtl/rggen_bus_if.sv
// rggen bus: a request is held by the master with valid=1 until the slave pulses
// ready for one cycle; status and read_data are valid whenever ready=1.
interface rggen_bus_if
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
);
    logic                       valid;
    logic [ADDRESS_WIDTH-1:0]   address;
    logic                       write;
    logic [BUS_WIDTH-1:0]       write_data;
    logic [BUS_WIDTH/8-1:0]     strobe;
    logic                       ready;
    rggen_status                status;
    logic [BUS_WIDTH-1:0]       read_data;

    modport master (
        output valid, address, write, write_data, strobe,
        input  ready, status, read_data
    );

    modport slave (
        input  valid, address, write, write_data, strobe,
        output ready, status, read_data
    );
endinterface

// File: rtl/rggen_address_decoder.sv
// Word-granular address range match: bits below LSB are ignored, and the
// access direction is qualified by READABLE/WRITABLE.
module rggen_address_decoder #(
    parameter int               WIDTH         = 8,
    parameter int               LSB           = 2,
    parameter logic [WIDTH-1:0] START_ADDRESS = '0,
    parameter logic [WIDTH-1:0] END_ADDRESS   = '0,
    parameter bit               READABLE      = 1'b1,
    parameter bit               WRITABLE      = 1'b1
) (
    input  logic [WIDTH-1:0] i_address,
    input  logic             i_write,
    input  logic             i_additional_match,
    output logic             o_match
);
    localparam logic [WIDTH-1:0] START_WORD = START_ADDRESS >> LSB;
    localparam logic [WIDTH-1:0] END_WORD   = END_ADDRESS >> LSB;

    logic [WIDTH-1:0] word;
    logic             access_ok;

    assign word      = i_address >> LSB;
    assign access_ok = i_write ? WRITABLE : READABLE;
    assign o_match   = (word >= START_WORD) && (word <= END_WORD) &&
                       access_ok && i_additional_match;
endmodule

// File: rtl/rggen_bus_responder_ram.sv
// rggen bus responder backed by a byte-strobed word array. Defining
// RGGEN_BUS_RESPONDER_WAIT_EN inserts WAIT_CYCLES wait states before ready.
module rggen_bus_responder_ram
    import rggen_rtl_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 8,
    parameter int                       BUS_WIDTH     = 32,
    parameter int                       WORDS         = 4,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS  = '0,
    parameter int                       WAIT_CYCLES   = 0
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    rggen_bus_if.slave                  bus_if,
    output logic [WORDS*BUS_WIDTH-1:0]  o_value
);
    localparam int BYTES       = BUS_WIDTH / 8;
    localparam int ADDRESS_LSB = $clog2(BYTES);
    localparam int INDEX_WIDTH = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [ADDRESS_WIDTH-1:0] END_ADDRESS =
        BASE_ADDRESS + ADDRESS_WIDTH'((WORDS - 1) * BYTES);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT    = 2'd1;
    localparam logic [1:0] RESPOND = 2'd2;

    logic [1:0]             state;
    logic                   accept;
    logic                   match;
    logic [ADDRESS_WIDTH-1:0] offset;
    logic [INDEX_WIDTH-1:0] index;
    logic [BUS_WIDTH-1:0]   mem [WORDS];
    rggen_status            status_q;
    logic [BUS_WIDTH-1:0]   read_data_q;

    assign accept = (state == IDLE) && bus_if.valid;
    assign offset = bus_if.address - BASE_ADDRESS;
    assign index  = INDEX_WIDTH'(offset >> ADDRESS_LSB);

    rggen_address_decoder #(
        .WIDTH         (ADDRESS_WIDTH),
        .LSB           (ADDRESS_LSB),
        .START_ADDRESS (BASE_ADDRESS),
        .END_ADDRESS   (END_ADDRESS),
        .READABLE      (1'b1),
        .WRITABLE      (1'b1)
    ) u_decoder (
        .i_address          (bus_if.address),
        .i_write            (bus_if.write),
        .i_additional_match (1'b1),
        .o_match            (match)
    );

`ifdef RGGEN_BUS_RESPONDER_WAIT_EN
    localparam int COUNT_WIDTH = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    logic [COUNT_WIDTH-1:0] count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus_if.valid) begin
                        if (WAIT_CYCLES == 0) begin
                            state <= RESPOND;
                        end else begin
                            count <= COUNT_WIDTH'(WAIT_CYCLES - 1);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (count == '0) begin
                        state <= RESPOND;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (bus_if.valid) state <= RESPOND;
                default: state <= IDLE;
            endcase
        end
    end
`endif

    // Writes land at the accept edge, so o_value changes before ready rises.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (accept && match && bus_if.write) begin
            for (int b = 0; b < BYTES; b++) begin
                if (bus_if.strobe[b]) begin
                    mem[index][8*b +: 8] <= bus_if.write_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            status_q    <= RGGEN_OKAY;
            read_data_q <= '0;
        end else if (accept) begin
            status_q    <= match ? RGGEN_OKAY : RGGEN_SLAVE_ERROR;
            read_data_q <= (match && !bus_if.write) ? mem[index] : '0;
        end
    end

    assign bus_if.ready     = (state == RESPOND);
    assign bus_if.status    = status_q;
    assign bus_if.read_data = read_data_q;

    for (genvar i = 0; i < WORDS; i++) begin : g_value
        assign o_value[i*BUS_WIDTH +: BUS_WIDTH] = mem[i];
    end
endmodule
